// File: rtl/iteration_pkg.sv
// +----------------------------------------------------------------------------+
// | iteration_pkg : shared FSM state type and phase-length helpers            |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package iteration_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PH_A   = 3'd1,
    ST_PH_M   = 3'd2,
    ST_PH_UPD = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int TMR_W       = 16;
  localparam int ITER_DEF    = 2;
  localparam int MV_LAT_DEF  = 3;
  localparam int MUX_LAT_DEF = 1;
  localparam int ADD_LAT_DEF = 1;

  // A matrix-vector phase covers the mux stage plus the M2V pipeline.
  function automatic int mv_phase_len(input int mux_lat, input int mv_lat);
    return mux_lat + mv_lat;
  endfunction

  // The update phase covers two chained adder stages.
  function automatic int upd_phase_len(input int add_lat);
    return 2 * add_lat;
  endfunction

endpackage

`default_nettype wire

// File: rtl/phase_timer.sv
// +----------------------------------------------------------------------------+
// | phase_timer : loadable, enable-gated down-counter with a zero flag         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en_i) begin
      if (load_i) begin
        cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - W'(1);
      end
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/iteration_ctrl.sv
// +----------------------------------------------------------------------------+
// | iteration_ctrl : sequences A-phase, M-phase and update for ITER iterations |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module iteration_ctrl
  import iteration_pkg::*;
#(
  parameter int ITER    = ITER_DEF,
  parameter int MV_LAT  = MV_LAT_DEF,
  parameter int MUX_LAT = MUX_LAT_DEF,
  parameter int ADD_LAT = ADD_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  output logic       sel_x,
  output logic       sel_v,
  output logic       sel_mat,
  output logic [7:0] iter_cnt,
  output logic       busy,
  output logic       done
);

  localparam int               MV_LEN   = mv_phase_len(MUX_LAT, MV_LAT);
  localparam int               UPD_LEN  = upd_phase_len(ADD_LAT);
  localparam logic [TMR_W-1:0] MV_LOAD  = TMR_W'(MV_LEN - 1);
  localparam logic [TMR_W-1:0] UPD_LOAD = TMR_W'(UPD_LEN - 1);
  localparam logic [7:0]       ITER_C   = 8'(ITER);

  if (ITER < 1 || ITER > 255) begin : g_iter_check
    $error("iteration_ctrl: ITER=%0d outside legal range 1..255", ITER);
  end

  if (MV_LEN < 1 || UPD_LEN < 1) begin : g_lat_check
    $error("iteration_ctrl: phase lengths must be at least one cycle");
  end

  state_e     state_q, state_d;
  logic [7:0] iter_cnt_q, iter_cnt_d, iter_inc;
  logic       sel_x_q, sel_x_d;
  logic       sel_v_q, sel_v_d;
  logic       sel_mat_q, sel_mat_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic       tmr_zero;

  phase_timer #(
    .W (TMR_W)
  ) u_phase_timer (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      iter_cnt_q <= '0;
      sel_x_q    <= 1'b0;
      sel_v_q    <= 1'b0;
      sel_mat_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
      sel_x_q    <= sel_x_d;
      sel_v_q    <= sel_v_d;
      sel_mat_q  <= sel_mat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Registered outputs are computed one cycle ahead so they change with the state.
  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    sel_x_d    = sel_x_q;
    sel_v_d    = sel_v_q;
    sel_mat_d  = sel_mat_q;
    busy_d     = busy_q;
    done_d     = done_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    iter_inc   = (iter_cnt_q == ITER_C) ? iter_cnt_q : iter_cnt_q + 8'd1;

    if (en) begin
      done_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d    = ST_PH_A;
            iter_cnt_d = '0;
            sel_x_d    = 1'b0;
            sel_v_d    = 1'b0;
            sel_mat_d  = 1'b0;
            busy_d     = 1'b1;
            tmr_load   = 1'b1;
            tmr_val    = MV_LOAD;
          end
        end
        ST_PH_A: begin
          if (tmr_zero) begin
            state_d   = ST_PH_M;
            sel_v_d   = 1'b1;
            sel_mat_d = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = MV_LOAD;
          end
        end
        ST_PH_M: begin
          if (tmr_zero) begin
            state_d  = ST_PH_UPD;
            tmr_load = 1'b1;
            tmr_val  = UPD_LOAD;
          end
        end
        ST_PH_UPD: begin
          if (tmr_zero) begin
            iter_cnt_d = iter_inc;
            sel_x_d    = 1'b1;
            if (iter_inc == ITER_C) begin
              state_d = ST_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d   = ST_PH_A;
              sel_v_d   = 1'b0;
              sel_mat_d = 1'b0;
              tmr_load  = 1'b1;
              tmr_val   = MV_LOAD;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign sel_x    = sel_x_q;
  assign sel_v    = sel_v_q;
  assign sel_mat  = sel_mat_q;
  assign iter_cnt = iter_cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

`default_nettype wire
